// File: rtl/jet_feature_frame_loader.sv
// ---------------------------------------------------------------------------
// jet_feature_frame_loader
//
// Upstream stage of the jet-tagging batchnorm/MLP core. Collects INPUT_SIZE
// feature words from a valid/ready stream into a fill buffer. It hands each
// complete frame to the core as a parallel array and then waits for the
// core's done edge. The buffer is double-buffered: the next frame fills while
// the core computes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   s_valid      feature word valid
//   s_ready      loader can accept a word (registered, ~fill_full)
//   s_data       signed Q(WIDTH-NFRAC).NFRAC feature word, passed through
//   s_last       final feature of a frame
//   core_start   one-cycle start pulse to the core (core input_ready)
//   core_done    core output_ready level; its rising edge ends RUN
//   frame_data   INPUT_SIZE x WIDTH frame presented to the core
//   busy         high while in START or RUN
//   frame_error  one-cycle pulse when a malformed frame is dropped
//
// Optional feature (macro LOADER_STATS_EN):
//   frames_issued   saturating count of core_start pulses
//   frames_dropped  saturating count of frame_error pulses
// ---------------------------------------------------------------------------
module jet_feature_frame_loader #(
  parameter int WIDTH      = 16,
  parameter int NFRAC      = 10,
  parameter int INPUT_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    core_start,
  input  logic                    core_done,
  output logic signed [WIDTH-1:0] frame_data [INPUT_SIZE],
  output logic                    busy,
  output logic                    frame_error
`ifdef LOADER_STATS_EN
  ,
  output logic [31:0]             frames_issued,
  output logic [15:0]             frames_dropped
`endif
);

  localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

  // The fixed-point format is only carried through; reject nonsense formats.
  if (NFRAC < 0 || NFRAC >= WIDTH) begin : g_bad_nfrac
    $error("jet_feature_frame_loader: NFRAC must lie in [0, WIDTH-1]");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN
  } state_e;

  state_e                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_fill_full;
  logic                    r_done_q;
  logic signed [WIDTH-1:0] r_fill_buf [INPUT_SIZE];

  logic w_accept;
  logic w_at_last;
  logic w_done_rise;

  assign s_ready     = ~r_fill_full;
  assign w_accept    = s_valid & ~r_fill_full;
  assign w_at_last   = (r_idx == LAST_IDX);
  assign w_done_rise = core_done & ~r_done_q;

  // NOTE: the fill buffer is deliberately not reset; a word is only consumed
  // after a full frame has overwritten every entry, and r_idx returning to 0
  // on reset already discards any partial fill.
  always_ff @(posedge clk) begin
    if (w_accept) r_fill_buf[r_idx] <= s_data;
  end

  // Fill control and core-side FSM share one block so r_fill_full has a
  // single driver: fill sets it only while it is 0, IDLE clears it only
  // while it is 1, so the two never collide.
  // NOTE: every state update uses <= so all reads in this block see the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_fill_full <= 1'b0;
      r_done_q    <= 1'b0;
      core_start  <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
      for (int i = 0; i < INPUT_SIZE; i++) frame_data[i] <= '0;
    end else begin
      r_done_q    <= core_done;
      frame_error <= 1'b0;

      if (w_accept) begin
        if (s_last && w_at_last) begin
          r_fill_full <= 1'b1;
          r_idx       <= '0;
        end else if (s_last || w_at_last) begin
          // Early s_last or missing s_last: drop the whole frame.
          r_idx       <= '0;
          frame_error <= 1'b1;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (r_fill_full) begin
            frame_data  <= r_fill_buf;
            r_fill_full <= 1'b0;
            core_start  <= 1'b1;
            busy        <= 1'b1;
            r_state     <= ST_START;
          end
        end
        ST_START: begin
          core_start <= 1'b0;
          r_state    <= ST_RUN;
        end
        ST_RUN: begin
          // Edge, not level: a done still high from the previous frame must
          // be seen low before it can end this run.
          if (w_done_rise) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef LOADER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frames_issued  <= '0;
      frames_dropped <= '0;
    end else begin
      if (core_start && (frames_issued != '1))
        frames_issued <= frames_issued + 32'd1;
      if (frame_error && (frames_dropped != '1))
        frames_dropped <= frames_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: doc/jet_feature_frame_loader.md
Name: jet_feature_frame_loader

Overview:
- Upstream stage of the jet-tagging batchnorm/MLP core.
- Accepts jet features one WIDTH-bit word per beat on a valid/ready stream and assembles INPUT_SIZE words into a parallel frame.
- Presents the frame to the core's input_data, pulses the core's input_ready, then waits for the core's output_ready before issuing the next frame.
- Double-buffered: the next frame fills while the core computes.

Parameters:
- WIDTH, 16, bits per feature word (signed Q(WIDTH-NFRAC).NFRAC, passed through unmodified).
- NFRAC, 10, fractional bits; informational only, no arithmetic is applied.
- INPUT_SIZE, 16, features per frame.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  feature word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  WIDTH  signed feature word.
- s_last  in  1  marks the final feature of a frame.
- core_start  out  1  one-cycle start pulse; drives the core's input_ready.
- core_done  in  1  core's output_ready (level).
- frame_data  out  WIDTH x INPUT_SIZE  unpacked array; drives the core's input_data.
- busy  out  1  high in START and RUN.
- frame_error  out  1  one-cycle pulse when a malformed frame is dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - frame_data all 0; core_start=0; busy=0; frame_error=0.
  - Fill index=0; fill_full=0; FSM=IDLE; core_done history register=0.
  - s_ready is 1 immediately after reset deasserts.
- Fill side:
  - A beat is accepted when s_valid && s_ready. The word is written to fill_buf[idx] and idx increments.
  - s_ready = ~fill_full (registered flag; no combinational path from s_valid).
  - Beat at idx==INPUT_SIZE-1 with s_last=1: fill_full<=1, idx<=0.
  - s_last=1 at idx<INPUT_SIZE-1, or s_last=0 at idx==INPUT_SIZE-1: drop the partial frame, idx<=0, pulse frame_error next cycle, fill_full stays 0.
- Core-side FSM:
  - IDLE: if fill_full, copy fill_buf to frame_data, clear fill_full, go to START.
  - START: core_start=1 for exactly this one cycle, then go to RUN.
  - RUN: wait for a core_done rising edge (core_done=1, previous sample=0), then go to IDLE. A core_done that is already high on entry to RUN is ignored until it has been seen low.
- frame_data changes only on the IDLE->START transition and is stable through START and RUN.
- Latency: last beat accepted in cycle N; fill_full=1 in N+1 (IDLE transfers); core_start=1 and new frame_data visible in N+2; s_ready=1 again in N+2.
- Back-to-back operation:
  - A second frame may fill completely during RUN. It then holds with s_ready=0 until RUN exits.
  - It is transferred in the first IDLE cycle after the core_done edge.
- A core_done edge outside RUN is ignored.
- Reset asserted mid-frame or mid-RUN: all state clears asynchronously and any partial fill is discarded.

Optional Feature:
- Macro LOADER_STATS_EN.
- Defined:
  - Adds output frames_issued[31:0], incremented on each core_start pulse.
  - Adds output frames_dropped[15:0], incremented on each frame_error pulse.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single frame: stream -304,378,253,-8,123,14,-399,-144,-399,-629,-664,-537,-586,-376,284,430 with s_last on word 15 -> core_start high exactly 2 cycles after the last beat; frame_data[0]=-304, frame_data[15]=430; busy=1 until a core_done edge is driven.
- Double buffering: send frame A, then frame B during RUN while holding core_done=0 -> s_ready=0 after B's 16th beat; frame_data stays A; on core_done 0->1, frame_data becomes B and core_start pulses once.
- Malformed frames: s_last on word 7 -> frame_error pulse, no core_start. A 16-word frame with s_last=0 -> frame_error. A following valid frame -> loads correctly starting at index 0.
- Stale done: core_done held high from a previous frame when RUN is entered -> FSM stays in RUN until core_done goes low then high again.
- Reset mid-fill: assert reset after 9 beats -> all outputs 0, s_ready=1 after release; the next 16-word frame is captured intact.
- With LOADER_STATS_EN: 3 good frames + 2 malformed -> frames_issued=3, frames_dropped=2.
